// File: rtl/dual_issue_if_id_reg.sv
// Dual-slot IF/ID register: 1-cycle load, with per-slot hold, bubble and clear, in-order split tracking, and a flush window. Stall masks hold slots in place; no valid/ready handshake.
// Optional HAZARD_STATS_EN adds saturating stall_cycles/split_count counters; when it is undefined, both ports read 0.
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID 1
`endif

module dual_issue_if_id_reg #(
  parameter int                     INSTR_WIDTH  = 32,
  parameter int                     ADDR_WIDTH   = 16,
  parameter int                     FLUSH_CYCLES = 1,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR    = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_valid,
  input  logic [INSTR_WIDTH-1:0]     fetch_instr0,
  input  logic [INSTR_WIDTH-1:0]     fetch_instr1,
  input  logic [ADDR_WIDTH-1:0]      fetch_pc0,
  input  logic [ADDR_WIDTH-1:0]      fetch_pc1,
  input  logic [`NUM_PIPE_MASKS-1:0] stall0,
  input  logic [`NUM_PIPE_MASKS-1:0] stall1,
  input  logic [`NUM_PIPE_MASKS-1:0] nop0,
  input  logic [`NUM_PIPE_MASKS-1:0] nop1,
  input  logic                       clear0,
  input  logic                       clear1,
  input  logic                       flush,
  output logic [INSTR_WIDTH-1:0]     if_id_instr0,
  output logic [INSTR_WIDTH-1:0]     if_id_instr1,
  output logic [ADDR_WIDTH-1:0]      if_id_pc0,
  output logic [ADDR_WIDTH-1:0]      if_id_pc1,
  output logic                       if_id_valid0,
  output logic                       if_id_valid1,
  output logic                       first,
  output logic                       split_active,
  output logic [15:0]                stall_cycles,
  output logic [15:0]                split_count
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {ST_PAIR, ST_SPLIT, ST_FLUSH} state_t;
  typedef enum logic [1:0] {ACT_HOLD, ACT_NOP, ACT_LOAD} act_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_split_slot;
  logic [CW-1:0]          r_flush_cnt;
  logic [INSTR_WIDTH-1:0] r_instr0, r_instr1;
  logic [ADDR_WIDTH-1:0]  r_pc0, r_pc1;
  logic                   r_valid0, r_valid1, r_first;
  act_t                   w_act0, w_act1;

  wire w_st0 = stall0[`PIPE_REG_IF_ID];
  wire w_st1 = stall1[`PIPE_REG_IF_ID];
  wire w_nop0 = nop0[`PIPE_REG_IF_ID];
  wire w_nop1 = nop1[`PIPE_REG_IF_ID];
  wire w_unused_masks = ^{stall0, stall1, nop0, nop1};

  // The flush edge itself is the first empty cycle, so the counter restarts at 1.
  wire w_flush_done = (r_state == ST_FLUSH) && (r_flush_cnt >= CW'(FLUSH_CYCLES));
  wire w_kill = flush || ((r_state == ST_FLUSH) && !w_flush_done);

  wire w_held_stall = r_split_slot ? w_st1 : w_st0;
  wire w_held_clear = r_split_slot ? clear1 : clear0;
  wire w_split_hold = (r_state == ST_SPLIT) && w_held_stall && !w_held_clear;
  wire w_enter_split = (r_state == ST_PAIR) && !flush &&
                       ((clear0 && !clear1 && w_st1) || (clear1 && !clear0 && w_st0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_PAIR;
      r_split_slot <= 1'b0;
      r_flush_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_enter_split) r_split_slot <= clear0;
      if (flush) r_flush_cnt <= CW'(1);
      else if ((r_state == ST_FLUSH) && !w_flush_done) r_flush_cnt <= r_flush_cnt + CW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_PAIR: begin
        if (flush) w_state_nxt = ST_FLUSH;
        else if (w_enter_split) w_state_nxt = ST_SPLIT;
      end
      ST_SPLIT: begin
        if (flush) w_state_nxt = ST_FLUSH;
        else if (!w_split_hold) w_state_nxt = ST_PAIR;
      end
      ST_FLUSH: begin
        if (!flush && w_flush_done) w_state_nxt = ST_PAIR;
      end
      default: w_state_nxt = ST_PAIR;
    endcase
  end

  always_comb begin
    w_act0 = ACT_LOAD;
    w_act1 = ACT_LOAD;
    if (w_kill) begin
      w_act0 = ACT_NOP;
      w_act1 = ACT_NOP;
    end else begin
      if (clear0) w_act0 = ACT_NOP;
      else if (w_st0) w_act0 = ACT_HOLD;
      else if (w_nop0) w_act0 = ACT_NOP;
      if (clear1) w_act1 = ACT_NOP;
      else if (w_st1) w_act1 = ACT_HOLD;
      else if (w_nop1) w_act1 = ACT_NOP;
      // The emptied slot must not overtake the older held word.
      if (w_split_hold) begin
        if (r_split_slot) w_act0 = ACT_NOP;
        else w_act1 = ACT_NOP;
      end
    end
    split_active = (r_state == ST_SPLIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr0 <= NOP_INSTR;
      r_instr1 <= NOP_INSTR;
      r_pc0    <= '0;
      r_pc1    <= '0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      r_first  <= 1'b0;
    end else begin
      case (w_act0)
        ACT_LOAD: begin
          r_instr0 <= fetch_instr0;
          r_pc0    <= fetch_pc0;
          r_valid0 <= fetch_valid;
        end
        ACT_NOP: begin
          r_instr0 <= NOP_INSTR;
          r_pc0    <= '0;
          r_valid0 <= 1'b0;
        end
        default: ;
      endcase
      case (w_act1)
        ACT_LOAD: begin
          r_instr1 <= fetch_instr1;
          r_pc1    <= fetch_pc1;
          r_valid1 <= fetch_valid;
        end
        ACT_NOP: begin
          r_instr1 <= NOP_INSTR;
          r_pc1    <= '0;
          r_valid1 <= 1'b0;
        end
        default: ;
      endcase
      if ((w_act0 == ACT_LOAD) && (w_act1 == ACT_LOAD) && fetch_valid)
        r_first <= (fetch_pc1 < fetch_pc0);
    end
  end

  assign if_id_instr0 = r_instr0;
  assign if_id_instr1 = r_instr1;
  assign if_id_pc0    = r_pc0;
  assign if_id_pc1    = r_pc1;
  assign if_id_valid0 = r_valid0;
  assign if_id_valid1 = r_valid1;
  assign first        = r_first;

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cycles, r_split_count;
  wire w_any_hold = (w_act0 == ACT_HOLD) || (w_act1 == ACT_HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_split_count  <= '0;
    end else begin
      if (w_any_hold && (r_stall_cycles != 16'hFFFF)) r_stall_cycles <= r_stall_cycles + 16'd1;
      if (w_enter_split && (r_split_count != 16'hFFFF)) r_split_count <= r_split_count + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign split_count  = r_split_count;
`else
  assign stall_cycles = 16'd0;
  assign split_count  = 16'd0;
`endif

endmodule
